// File: rtl/cpu_ctrl.sv
// Two-step (FETCH/EXEC) control unit for a 16-bit instruction, 4-bit ALU datapath.
// Owns the program counter, instruction register and the registered z/c/s flags.
module cpu_ctrl #(
    parameter int PC_W = 10,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [IW-1:0]   instr,
    input  logic            zero_in,
    input  logic            carry_in,
    input  logic            sign_in,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      alu_op,
    output logic            l,
    output logic [3:0]      ra,
    output logic [3:0]      rb,
    output logic [3:0]      rd,
    output logic [3:0]      imm,
    output logic            sel_imm,
    output logic            we,
    output logic            z,
    output logic            c,
    output logic            s,
    output logic            halt
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ir;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic            flags_upd;
    logic            is_alu, is_jmp, is_loadi, is_halt;
    logic            jmp_taken;

    assign is_alu   = ~ir[15];
    assign is_jmp   = (ir[15:14] == 2'b10);
    assign is_loadi = (ir[15:12] == 4'hC);
    assign is_halt  = (ir[15:12] == 4'hF);

    // Field outputs track ir in every state; only we/sel_imm are state-qualified.
    assign l      = ir[14];
    assign alu_op = ir[13:12];
    assign ra     = ir[11:8];
    assign rb     = ir[7:4];
    assign rd     = ir[3:0];
    assign imm    = ir[7:4];
    assign halt   = (state == ST_HALT);

    // Wraps naturally at all-ones because the sum is truncated to PC_W bits.
    assign pc_inc = pc + PC_W'(1);

    // Conditions read the registered flags, i.e. the result of the last ALU op.
    always_comb begin
        case (ir[13:12])
            2'b00:   jmp_taken = 1'b1;
            2'b01:   jmp_taken = z;
            2'b10:   jmp_taken = c;
            default: jmp_taken = s;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        flags_upd = 1'b0;
        we        = 1'b0;
        sel_imm   = 1'b0;
        case (state)
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                pc_nxt    = pc_inc;
                if (is_alu) begin
                    we        = en;
                    flags_upd = 1'b1;
                end else if (is_jmp) begin
                    if (jmp_taken) pc_nxt = ir[PC_W-1:0];
                end else if (is_loadi) begin
                    we      = en;
                    sel_imm = 1'b1;
                end else if (is_halt) begin
                    state_nxt = ST_HALT;
                    pc_nxt    = pc;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // NOTE: ir is a plain register, not a memory, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
            ir    <= '0;
            pc    <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            s     <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == ST_FETCH) ir <= instr;
            if (flags_upd) begin
                z <= zero_in;
                c <= carry_in;
                s <= sign_in;
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: stimulus pushes expected register-file writes,
// a monitor pops and compares them whenever the DUT pulses we.
module tb_cpu_ctrl;

    localparam int PC_W = 10;
    localparam int IW   = 16;

    logic            clk;
    logic            reset;
    logic            en;
    logic [IW-1:0]   instr;
    logic            zero_in, carry_in, sign_in;
    logic [PC_W-1:0] pc;
    logic [1:0]      alu_op;
    logic            l;
    logic [3:0]      ra, rb, rd, imm;
    logic            sel_imm, we, z, c, s, halt;

    logic [IW-1:0] rom [0:(1<<PC_W)-1];

    typedef struct packed {
        logic       sel;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] imm;
        logic [1:0] op;
        logic       l;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    cpu_ctrl #(.PC_W(PC_W), .IW(IW)) dut (
        .clk(clk), .reset(reset), .en(en), .instr(instr),
        .zero_in(zero_in), .carry_in(carry_in), .sign_in(sign_in),
        .pc(pc), .alu_op(alu_op), .l(l), .ra(ra), .rb(rb), .rd(rd), .imm(imm),
        .sel_imm(sel_imm), .we(we), .z(z), .c(c), .s(s), .halt(halt)
    );

    assign instr = rom[pc];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic [2:0] exp_zcs);
        check(name, 32'({z, c, s}), 32'(exp_zcs));
    endtask

    // Monitor: every we pulse must match the oldest outstanding expectation.
    initial begin
        wr_t act, e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                act = '{sel: sel_imm, rd: rd, ra: ra, rb: rb, imm: imm, op: alu_op, l: l};
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(act), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_port", 32'(act), 32'(e));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = 16'hD000;
        rom[0]    = 16'h0123;
        rom[1]    = 16'h9005;
        rom[5]    = 16'hC0A7;
        rom[6]    = 16'h1456;
        rom[7]    = 16'h9005;
        rom[8]    = 16'hA00C;
        rom[12]   = 16'hB00F;
        rom[13]   = 16'h8014;
        rom[20]   = 16'h7ABC;
        rom[21]   = 16'hE000;
        rom[22]   = 16'h83FF;
        rom[1023] = 16'hD000;

        reset = 1'b0; en = 1'b1;
        zero_in = 1'b1; carry_in = 1'b1; sign_in = 1'b1;
        step(2);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_halt", 32'(halt), 32'd0);
        check_flags("reset_flags", 3'b000);
        check("reset_we_sel", 32'({we, sel_imm}), 32'd0);
        reset = 1'b1;

        // ADD-type at 0: zero flag captured, pc advances.
        zero_in = 1'b1; carry_in = 1'b0; sign_in = 1'b0;
        exp_q.push_back('{sel: 1'b0, rd: 4'h3, ra: 4'h1, rb: 4'h2, imm: 4'h2, op: 2'b00, l: 1'b0});
        step(2);
        check("alu_pc", 32'(pc), 32'd1);
        check_flags("alu_flags", 3'b100);

        // Jump-if-zero taken; ALU inputs change but flags must not.
        zero_in = 1'b0; carry_in = 1'b1; sign_in = 1'b1;
        step(2);
        check("jz_taken_pc", 32'(pc), 32'd5);
        check_flags("jz_flags_hold", 3'b100);

        exp_q.push_back('{sel: 1'b1, rd: 4'h7, ra: 4'h0, rb: 4'hA, imm: 4'hA, op: 2'b00, l: 1'b1});
        step(2);
        check("loadi_pc", 32'(pc), 32'd6);
        check_flags("loadi_flags_hold", 3'b100);

        zero_in = 1'b0; carry_in = 1'b1; sign_in = 1'b0;
        exp_q.push_back('{sel: 1'b0, rd: 4'h6, ra: 4'h4, rb: 4'h5, imm: 4'h5, op: 2'b01, l: 1'b0});
        step(2);
        check("alu2_pc", 32'(pc), 32'd7);
        check_flags("alu2_flags", 3'b010);

        carry_in = 1'b0;
        step(2);
        check("jz_not_taken_pc", 32'(pc), 32'd8);
        step(2);
        check("jc_taken_pc", 32'(pc), 32'd12);
        step(2);
        check("js_not_taken_pc", 32'(pc), 32'd13);
        step(2);
        check("jmp_always_pc", 32'(pc), 32'd20);

        // Stall three cycles in EXEC of an ALU op: nothing may move.
        zero_in = 1'b1; carry_in = 1'b0; sign_in = 1'b1;
        exp_q.push_back('{sel: 1'b0, rd: 4'hC, ra: 4'hA, rb: 4'hB, imm: 4'hB, op: 2'b11, l: 1'b1});
        step(1);
        en = 1'b0;
        step(3);
        check("stall_pc", 32'(pc), 32'd20);
        check_flags("stall_flags", 3'b010);
        en = 1'b1;
        step(1);
        check("resume_pc", 32'(pc), 32'd21);
        check_flags("resume_flags", 3'b101);

        step(2);
        check("nop_pc", 32'(pc), 32'd22);
        step(2);
        check("jmp_top_pc", 32'(pc), 32'd1023);
        step(2);
        check("wrap_pc", 32'(pc), 32'd0);
        check_flags("nop_flags_hold", 3'b101);
        en = 1'b0;

        // HALT: jump to 50, halt there, hold, then leave by reset.
        rom[0]  = 16'h8032;
        rom[50] = 16'hF000;
        rom[51] = 16'h0123;
        reset = 1'b0;
        step(1);
        reset = 1'b1; en = 1'b1;
        step(2);
        check("halt_jmp_pc", 32'(pc), 32'd50);
        step(2);
        check("halt_set", 32'(halt), 32'd1);
        check("halt_pc", 32'(pc), 32'd50);
        step(20);
        check("halt_held", 32'(halt), 32'd1);
        check("halt_pc_held", 32'(pc), 32'd50);
        reset = 1'b0;
        #1;
        check("halt_reset_pc", 32'(pc), 32'd0);
        check("halt_reset_halt", 32'(halt), 32'd0);

        // Reset in the middle of EXEC aborts the ALU op entirely.
        rom[0] = 16'h0123;
        zero_in = 1'b1; carry_in = 1'b1; sign_in = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        check("abort_pc", 32'(pc), 32'd0);
        check_flags("abort_flags", 3'b000);
        check("abort_we", 32'(we), 32'd0);

        // Jump to own address loops forever without halting.
        rom[0] = 16'h8000;
        reset = 1'b1;
        step(10);
        check("self_loop_pc", 32'(pc), 32'd0);
        check("self_loop_halt", 32'(halt), 32'd0);
        step(1);

        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter PC_W, default 10, program-counter and jump-target width.
REQ-002 Parameter IW, default 16, instruction width; only IW=16 is supported.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run enable; 0 freezes all state.
REQ-006 instr  input  IW  instruction word from combinational ROM addressed by pc.
REQ-007 zero_in, carry_in, sign_in  input  1 each  combinational flags from the 4-bit ALU.
REQ-008 pc  output  PC_W  registered program counter, ROM address.
REQ-009 alu_op  output  2  ALUOp to the ALU.
REQ-010 l  output  1  logic/arithmetic select to the ALU.
REQ-011 ra, rb, rd  output  4 each  register-file read A, read B, write addresses.
REQ-012 imm  output  4  immediate data for LOADI.
REQ-013 sel_imm  output  1  1 selects imm instead of ALU result as write data.
REQ-014 we  output  1  register-file write enable, one-cycle pulse.
REQ-015 z, c, s  output  1 each  registered flags.
REQ-016 halt  output  1  high while in HALT state.

Function
REQ-017 FSM states FETCH, EXEC, HALT; every instruction takes exactly 2 enabled cycles (FETCH then EXEC).
REQ-018 FETCH: ir <= instr; next state EXEC; pc, flags unchanged; we=0.
REQ-019 Decode from ir: ir[15]=0 ALU op; ir[15:14]=10 jump; ir[15:12]=1100 LOADI; ir[15:12]=1111 HALT; 1101, 1110 NOP.
REQ-020 ALU op: l=ir[14], alu_op=ir[13:12], ra=ir[11:8], rb=ir[7:4], rd=ir[3:0]; in EXEC we=1, sel_imm=0.
REQ-021 ALU op EXEC edge: z<=zero_in, c<=carry_in, s<=sign_in; pc<=pc+1.
REQ-022 Flags change only on ALU ops; jumps, LOADI, NOP, HALT leave z/c/s unchanged.
REQ-023 Jump: cond=ir[13:12]; 00 always, 01 if z, 10 if c, 11 if s; taken pc<=ir[PC_W-1:0], else pc<=pc+1; we=0.
REQ-024 Jump conditions use registered flags, so the flags of the immediately preceding ALU op apply.
REQ-025 LOADI: rd=ir[3:0], imm=ir[7:4], sel_imm=1, we=1 in EXEC; pc<=pc+1.
REQ-026 NOP: we=0, pc<=pc+1.
REQ-027 HALT: EXEC goes to HALT, pc unchanged; HALT is left only by reset; halt=1, we=0 in HALT.
REQ-028 pc increment wraps modulo 2^PC_W (all ones -> 0).
REQ-029 Outside EXEC, we=0 and sel_imm=0; alu_op, l, ra, rb, rd, imm follow ir combinationally in all states.
REQ-030 en=0: state, ir, pc and flags hold; we forced 0; resumes the same step when en returns to 1.
REQ-031 Taken jump to own address is legal and loops indefinitely.

Reset
REQ-032 reset low asynchronously forces state=FETCH, pc=0, ir=0, z=c=s=0, halt=0, we=0, sel_imm=0.
REQ-033 reset asserted mid-EXEC aborts the instruction: no write, no flag or pc update.
REQ-034 First fetch occurs on the first enabled rising edge after reset deasserts.

Verification
REQ-035 Reset then ROM[0]=0x0123 (ADD-type, ALUOp=00, L=0), zero_in=1 -> cycle 2: we=1, ra=1, rb=2, rd=3; after: z=1, pc=1.
REQ-036 ROM[1]=0x9005 with z=1 -> pc=5; same with z=0 -> pc=2; flags unchanged.
REQ-037 ROM[k]=0xC0A7 -> EXEC: we=1, sel_imm=1, rd=7, imm=0xA; pc=k+1.
REQ-038 pc=1023 executing NOP (0xD000) -> pc=0.
REQ-039 ROM[n]=0xF000 -> halt=1 after EXEC, pc=n held for 20 cycles, we=0; reset low -> pc=0, halt=0.
REQ-040 en=0 for 3 cycles during EXEC of ALU op -> no we pulse, pc/flags frozen; en=1 -> single we pulse, then normal sequence.
